// File: rtl/afifo_arb_pkg.sv
// Shared definitions for the async-FIFO write arbiter.
// Holds the arbiter FSM state encoding and the default parameter values
// used by afifo_wr_arbiter and afifo_rr_pick.
package afifo_arb_pkg;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 32;
  localparam int BURST_LEN = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/afifo_rr_pick.sv
// Round-robin picker: finds the first requesting index strictly after
// last_owner, wrapping modulo NUM_REQ. Purely combinational.
// Ports: req (request vector), last_owner (index of previous winner),
//        pick (one-hot winner), pick_idx (winner index), pick_any (any request).
module afifo_rr_pick #(
  parameter int NUM_REQ = afifo_arb_pkg::NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_owner,
  output logic [NUM_REQ-1:0]         pick,
  output logic [$clog2(NUM_REQ)-1:0] pick_idx,
  output logic                       pick_any
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic found;
  int   idx;

  assign pick_any = |req;

  // Scan offsets 1..NUM_REQ from the last owner, so the last owner itself
  // is considered only after every other requester.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_owner) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/afifo_wr_arbiter.sv
// Burst round-robin arbiter feeding the write side of an async FIFO.
// Ports: wr_clk/reset (sync, active-high); req_valid/req_data/req_ready per
//        requester; grant (registered one-hot owner); wr_en/data_in (registered
//        FIFO write); fifo_full/fifo_almost_full (throttle inputs);
//        beat_total (per-requester 16-bit accepted-word counters) only when
//        AFIFO_ARB_STATS_EN is defined.
module afifo_wr_arbiter #(
  parameter int NUM_REQ   = afifo_arb_pkg::NUM_REQ,
  parameter int DATA_W    = afifo_arb_pkg::DATA_W,
  parameter int BURST_LEN = afifo_arb_pkg::BURST_LEN
) (
  input  logic                      wr_clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      wr_en,
  output logic [DATA_W-1:0]         data_in,
  input  logic                      fifo_full,
  input  logic                      fifo_almost_full
`ifdef AFIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     beat_total
`endif
);

  import afifo_arb_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  arb_state_t         state, state_n;
  logic [NUM_REQ-1:0] grant_n;
  logic [IDX_W-1:0]   last_owner, last_owner_n;
  logic [CNT_W-1:0]   beat_cnt, beat_cnt_n;
  logic               throttle;
  logic               accept;
  logic [DATA_W-1:0]  owner_word;
  logic [NUM_REQ-1:0] pick;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  // almost_full is included so the write already registered in flight
  // always has a slot when the FIFO is one word from full.
  assign throttle = fifo_full | fifo_almost_full;

  // Ready is the grant itself, independent of the owner's valid.
  assign req_ready = (state == BURST && !throttle) ? grant : '0;
  assign accept    = |(req_valid & req_ready);

  // last_owner doubles as the current owner index while in BURST.
  assign owner_word = req_data[int'(last_owner)*DATA_W +: DATA_W];

  afifo_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req        (req_valid),
    .last_owner (last_owner),
    .pick       (pick),
    .pick_idx   (pick_idx),
    .pick_any   (pick_any)
  );

  always_comb begin
    state_n      = state;
    grant_n      = grant;
    last_owner_n = last_owner;
    beat_cnt_n   = beat_cnt;
    case (state)
      IDLE: begin
        grant_n = '0;
        if (pick_any && !throttle) begin
          state_n      = BURST;
          grant_n      = pick;
          last_owner_n = pick_idx;
          beat_cnt_n   = '0;
        end
      end
      BURST: begin
        if (!req_valid[last_owner]) begin
          // Owner went quiet: give up the grant immediately.
          state_n = IDLE;
          grant_n = '0;
        end else if (accept) begin
          beat_cnt_n = beat_cnt + CNT_W'(1);
          if (beat_cnt_n == CNT_W'(BURST_LEN)) begin
            state_n = IDLE;
            grant_n = '0;
          end
        end
        // Throttled with owner still valid: everything holds.
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_owner <= IDX_W'(NUM_REQ - 1);
      beat_cnt   <= '0;
      wr_en      <= 1'b0;
      data_in    <= '0;
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      last_owner <= last_owner_n;
      beat_cnt   <= beat_cnt_n;
      wr_en      <= accept;
      if (accept) data_in <= owner_word;
    end
  end

`ifdef AFIFO_ARB_STATS_EN
  always_ff @(posedge wr_clk) begin
    if (reset) begin
      beat_total <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i])
          beat_total[i*16 +: 16] <= beat_total[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Self-checking bench for afifo_wr_arbiter (default parameters).
// A cycle table covers reset, idle throttling, grant/ready timing and
// owner drop; short sequences cover bursts, round-robin order, mid-burst
// throttle, owner drop and reset abort.
module tb_afifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;

  logic             wr_clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    grant;
  logic             wr_en;
  logic [DW-1:0]    data_in;
  logic             fifo_full;
  logic             fifo_almost_full;
`ifdef AFIFO_ARB_STATS_EN
  logic [NR*16-1:0] beat_total;
`endif

  always #5 wr_clk = ~wr_clk;

  afifo_wr_arbiter dut (
    .wr_clk           (wr_clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .grant            (grant),
    .wr_en            (wr_en),
    .data_in          (data_in),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full)
`ifdef AFIFO_ARB_STATS_EN
    ,
    .beat_total       (beat_total)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- cycle table ----------------
  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic        af;
    logic        full;
    logic [3:0]  exp_ready;  // before the edge
    logic [3:0]  exp_grant;  // after the edge
    logic        exp_wr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vt[16];

  // ---------------- requester model ----------------
  typedef struct {
    int          cyc;
    int          owner;
    logic [31:0] data;
  } wr_t;

  logic [NR-1:0] en;
  int            rem[NR];
  int            seq[NR];
  logic [31:0]   base[NR];
  int            cyc;
  int            af_left;
  wr_t           wlog[$];
  logic [3:0]    glog[$];

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]          = en[i] && (rem[i] > 0);
      req_data[i*DW +: DW]  = base[i] + 32'(seq[i]);
    end
    fifo_full        = 1'b0;
    fifo_almost_full = (af_left > 0);
  endtask

  // Called at posedge+1; returns at the next posedge+1 with logs updated.
  task automatic step();
    logic [NR-1:0] acc;
    int            own;
    #1;
    acc = req_valid & req_ready;
    @(posedge wr_clk);
    #1;
    cyc++;
    own = -1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        seq[i]++;
        rem[i]--;
        own = i;
      end
    end
    glog.push_back(grant);
    if (wr_en) wlog.push_back('{cyc, own, data_in});
    if (af_left > 0) af_left--;
    drive();
  endtask

  task automatic model_reset();
    reset = 1'b1;
    en = '0;
    af_left = 0;
    for (int i = 0; i < NR; i++) begin
      rem[i]  = 0;
      seq[i]  = 0;
      base[i] = 32'h0;
    end
    drive();
    @(posedge wr_clk); #1;
    @(posedge wr_clk); #1;
    reset = 1'b0;
    cyc = 0;
    wlog.delete();
    glog.delete();
    drive();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  c;
    bit  thr;
    bit  done;

    reset = 1'b1; req_valid = '0; req_data = '0;
    fifo_full = 1'b0; fifo_almost_full = 1'b0;
    en = '0; af_left = 0; cyc = 0;
    for (int i = 0; i < NR; i++) begin rem[i] = 0; seq[i] = 0; base[i] = 32'h0; end

    //         rst  vld      af    full   ready    grant    wr    data
    vt[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0};
    vt[1]  = '{1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0};
    vt[2]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0};
    vt[3]  = '{1'b0, 4'b0010, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0};
    vt[4]  = '{1'b0, 4'b0010, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 32'h0};
    vt[5]  = '{1'b0, 4'b0010, 1'b0, 1'b0, 4'b0000, 4'b0010, 1'b0, 32'h0};
    vt[6]  = '{1'b0, 4'b0010, 1'b0, 1'b0, 4'b0010, 4'b0010, 1'b1, 32'h22222222};
    vt[7]  = '{1'b0, 4'b0010, 1'b1, 1'b0, 4'b0000, 4'b0010, 1'b0, 32'h22222222};
    vt[8]  = '{1'b0, 4'b0010, 1'b0, 1'b1, 4'b0000, 4'b0010, 1'b0, 32'h22222222};
    vt[9]  = '{1'b0, 4'b0110, 1'b0, 1'b0, 4'b0010, 4'b0010, 1'b1, 32'h22222222};
    vt[10] = '{1'b0, 4'b0100, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0, 32'h22222222};
    vt[11] = '{1'b0, 4'b0101, 1'b0, 1'b0, 4'b0000, 4'b0100, 1'b0, 32'h22222222};
    vt[12] = '{1'b0, 4'b0101, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 32'h33333333};
    vt[13] = '{1'b1, 4'b0101, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0, 32'h0};
    vt[14] = '{1'b0, 4'b1001, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 32'h0};
    vt[15] = '{1'b0, 4'b1001, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b1, 32'h11111111};

    @(posedge wr_clk); #1;
    @(posedge wr_clk); #1;

    req_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    for (int i = 0; i < 16; i++) begin
      reset            = vt[i].rst;
      req_valid        = vt[i].vld;
      fifo_almost_full = vt[i].af;
      fifo_full        = vt[i].full;
      #1;
      chk($sformatf("tbl%0d_ready", i), req_ready, vt[i].exp_ready);
      @(posedge wr_clk); #1;
      chk($sformatf("tbl%0d_grant", i), grant, vt[i].exp_grant);
      chk($sformatf("tbl%0d_wr_en", i), wr_en, vt[i].exp_wr);
      chk($sformatf("tbl%0d_data", i), data_in, vt[i].exp_data);
    end

    // ---- single requester, 10 words: 8-beat burst, gap, 2 beats ----
    model_reset();
    base[2] = 32'hA0; rem[2] = 10; en = 4'b0100; drive();
    step();
    chk("A_first_grant", grant, 4'b0100);
    for (int t = 0; t < 40 && wlog.size() < 10; t++) step();
    chk("A_write_count", wlog.size(), 10);
    if (wlog.size() == 10) begin
      for (int k = 0; k < 10; k++) chk($sformatf("A_data%0d", k), wlog[k].data, 32'hA0 + k);
      chk("A_burst_span", wlog[7].cyc - wlog[0].cyc, 7);
      chk("A_idle_gap", wlog[8].cyc - wlog[7].cyc, 2);
      chk("A_tail_span", wlog[9].cyc - wlog[8].cyc, 1);
    end

    // ---- all four requesting: order 0,1,2,3,0,1,2,3 ----
    model_reset();
    for (int i = 0; i < NR; i++) begin base[i] = 32'h1000 * (i + 1); rem[i] = 100; end
    en = 4'b1111; drive();
    for (int t = 0; t < 300 && wlog.size() < 64; t++) step();
    chk("B_write_count", wlog.size(), 64);
`ifdef AFIFO_ARB_STATS_EN
    for (int i = 0; i < NR; i++)
      chk($sformatf("B_beat_total%0d", i), beat_total[i*16 +: 16], 16);
`endif
    if (wlog.size() == 64) begin
      for (int w = 0; w < 64; w++) begin
        int b, k, o, s;
        b = w / 8; k = w % 8; o = b % 4; s = (b / 4) * 8 + k;
        if (k == 0) chk($sformatf("B_owner_burst%0d", b), wlog[w].owner, o);
        chk($sformatf("B_data%0d", w), wlog[w].data, base[o] + 32'(s));
      end
      for (int b = 0; b < 8; b++)
        chk($sformatf("B_consec%0d", b), wlog[8*b+7].cyc - wlog[8*b].cyc, 7);
    end

    // ---- almost_full for 5 cycles after beat 3 ----
    model_reset();
    base[0] = 32'h5000; rem[0] = 8; en = 4'b0001; drive();
    done = 1'b0;
    for (int t = 0; t < 60 && wlog.size() < 8; t++) begin
      thr = fifo_almost_full;
      step();
      if (thr) begin
        chk("C_throttle_wr_en", wr_en, 1'b0);
        chk("C_throttle_grant", grant, 4'b0001);
      end
      if (!done && seq[0] == 3) begin
        done = 1'b1;
        af_left = 5;
        drive();
      end
    end
    chk("C_write_count", wlog.size(), 8);
    if (wlog.size() == 8) begin
      for (int k = 0; k < 8; k++) chk($sformatf("C_data%0d", k), wlog[k].data, 32'h5000 + k);
      chk("C_resume_gap", wlog[3].cyc - wlog[2].cyc, 6);
    end

    // ---- requester 1 drops after 2 beats, requester 2 follows ----
    model_reset();
    base[1] = 32'h6100; base[2] = 32'h6200; rem[1] = 2; rem[2] = 3;
    en = 4'b0110; drive();
    for (int t = 0; t < 40 && wlog.size() < 5; t++) step();
    chk("D_write_count", wlog.size(), 5);
    if (wlog.size() == 5) begin
      chk("D_owner0", wlog[0].owner, 1);
      chk("D_owner1", wlog[1].owner, 1);
      chk("D_owner2", wlog[2].owner, 2);
      chk("D_data2", wlog[2].data, 32'h6200);
      c = wlog[1].cyc;
      if (glog.size() > c + 1) begin
        chk("D_idle_after_drop", glog[c], 4'b0000);
        chk("D_next_grant", glog[c+1], 4'b0100);
      end else begin
        chk("D_grant_log_len", glog.size(), c + 2);
      end
    end

    // ---- reset during beat 5 of requester 3 ----
    model_reset();
    base[3] = 32'h7000; rem[3] = 8; en = 4'b1000; drive();
    for (int t = 0; t < 30 && seq[3] < 4; t++) step();
    chk("E_beats_before_reset", wlog.size(), 4);
    reset = 1'b1;
    step();
    chk("E_wr_en_after_reset", wr_en, 1'b0);
    chk("E_grant_after_reset", grant, 4'b0000);
    reset = 1'b0;
    base[0] = 32'h7100; rem[0] = 8; en = 4'b1001; drive();
    step();
    chk("E_first_grant", grant, 4'b0001);
    step();
    chk("E_first_wr_en", wr_en, 1'b1);
    chk("E_first_data", data_in, 32'h7100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
